// File: rtl/lu_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : lu_pkg
//  Purpose : Shared definitions for the serial driver of the 1-bit gate LU:
//            opcode constants ({select_group, select_op}), the driver FSM
//            state type and a reference model of the 1-bit LU.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package lu_pkg;

   localparam logic [1:0] LU_NAND = 2'b00;
   localparam logic [1:0] LU_AND  = 2'b01;
   localparam logic [1:0] LU_NOR  = 2'b10;
   localparam logic [1:0] LU_OR   = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Expected output of the 1-bit LU for one bit pair; op = {group, op}.
   function automatic logic lu_ref(input logic a, input logic b, input logic [1:0] op);
      logic r;
      case (op)
         LU_NAND: r = ~(a & b);
         LU_AND:  r = a & b;
         LU_NOR:  r = ~(a | b);
         default: r = a | b;
      endcase
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/lu_serial_driver.sv
`default_nettype none
// ============================================================================
//  Module  : lu_serial_driver
//  Purpose : Captures a WIDTH-bit operand pair and opcode, streams one bit per
//            clock (LSB first) into an external 1-bit gate LU, and assembles the
//            LU output into a WIDTH-bit result. A one-cycle done pulse marks
//            completion; a start in DONE chains straight into the next op.
//  Ports   : clk, rst_n (async, active low)
//            start, op_a, op_b, select_op, select_group   - command in
//            lu_a, lu_b, lu_select_op, lu_select_group    - to the LU
//            lu_result                                    - from the LU
//            result, busy, done                           - status out
//            mismatch (only with LU_SELF_CHECK_EN)        - sticky LU check
//  Config  : `define LU_SELF_CHECK_EN adds an internal reference checker and
//            the mismatch output.
//  Rev     : 1.0  initial release
// ============================================================================
module lu_serial_driver
   import lu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             select_op,
   input  logic             select_group,
   output logic             lu_a,
   output logic             lu_b,
   output logic             lu_select_op,
   output logic             lu_select_group,
   input  logic             lu_result,
   output logic [WIDTH-1:0] result,
   output logic             busy,
   output logic             done
`ifdef LU_SELF_CHECK_EN
   ,
   output logic             mismatch
`endif
);

   localparam int               IDX_W    = $clog2(WIDTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             sel_op_q, sel_op_d;
   logic             sel_group_q, sel_group_d;
   logic             accept;
`ifdef LU_SELF_CHECK_EN
   logic             mismatch_q, mismatch_d;
`endif

   // Start is honoured only when no operation is in flight.
   assign accept = start && ((state_q == IDLE) || (state_q == DONE));

   // ---------------- state / datapath register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         result_q    <= '0;
         sel_op_q    <= 1'b0;
         sel_group_q <= 1'b0;
`ifdef LU_SELF_CHECK_EN
         mismatch_q  <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         a_q         <= a_d;
         b_q         <= b_d;
         result_q    <= result_d;
         sel_op_q    <= sel_op_d;
         sel_group_q <= sel_group_d;
`ifdef LU_SELF_CHECK_EN
         mismatch_q  <= mismatch_d;
`endif
      end
   end

   // ---------------- next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = SHIFT;
         SHIFT:   if (idx_q == LAST_IDX) state_d = DONE;
         DONE:    state_d = start ? SHIFT : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---------------- datapath next values ----------------
   always_comb begin
      idx_d       = idx_q;
      a_d         = a_q;
      b_d         = b_q;
      result_d    = result_q;
      sel_op_d    = sel_op_q;
      sel_group_d = sel_group_q;
      if (accept) begin
         a_d         = op_a;
         b_d         = op_b;
         sel_op_d    = select_op;
         sel_group_d = select_group;
         idx_d       = '0;
      end else if (state_q == SHIFT) begin
         // Result is built in place; the index parks at the last bit.
         result_d[idx_q] = lu_result;
         if (idx_q != LAST_IDX) idx_d = idx_q + IDX_W'(1);
      end
   end

`ifdef LU_SELF_CHECK_EN
   always_comb begin
      mismatch_d = mismatch_q;
      if (accept)
         mismatch_d = 1'b0;
      else if ((state_q == SHIFT) &&
               (lu_ref(a_q[idx_q], b_q[idx_q], {sel_group_q, sel_op_q}) != lu_result))
         mismatch_d = 1'b1;
   end

   assign mismatch = mismatch_q;
`endif

   // ---------------- outputs ----------------
   always_comb begin
      busy            = (state_q == SHIFT);
      done            = (state_q == DONE);
      lu_a            = (state_q == SHIFT) ? a_q[idx_q] : 1'b0;
      lu_b            = (state_q == SHIFT) ? b_q[idx_q] : 1'b0;
      lu_select_op    = sel_op_q;
      lu_select_group = sel_group_q;
      result          = result_q;
   end

endmodule
`default_nettype wire

// File: tb/tb_lu_serial_driver.sv
`default_nettype none
// ============================================================================
//  Module  : tb_lu_serial_driver
//  Purpose : Self-checking bench for lu_serial_driver (WIDTH=8) with a
//            behavioural 1-bit gate LU beside it. Expected words come from a
//            whole-word model of the four gate functions.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_lu_serial_driver;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [W-1:0] op_a, op_b;
   logic         select_op, select_group;
   logic         lu_a, lu_b, lu_select_op, lu_select_group;
   logic         lu_result;
   logic [W-1:0] result;
   logic         busy, done;
   logic         lu_force_en;
`ifdef LU_SELF_CHECK_EN
   logic         mismatch;
`endif

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   // Behavioural 1-bit LU; lu_force_en pins its output low to model a fault.
   assign lu_result = lu_force_en ? 1'b0 :
                      (lu_select_group ? (lu_select_op ? (lu_a | lu_b) : ~(lu_a | lu_b))
                                       : (lu_select_op ? (lu_a & lu_b) : ~(lu_a & lu_b)));

   lu_serial_driver #(.WIDTH(W)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .start           (start),
      .op_a            (op_a),
      .op_b            (op_b),
      .select_op       (select_op),
      .select_group    (select_group),
      .lu_a            (lu_a),
      .lu_b            (lu_b),
      .lu_select_op    (lu_select_op),
      .lu_select_group (lu_select_group),
      .lu_result       (lu_result),
      .result          (result),
      .busy            (busy),
      .done            (done)
`ifdef LU_SELF_CHECK_EN
      ,
      .mismatch        (mismatch)
`endif
   );

   // Whole-word reference: {g,o} 00 NAND, 01 AND, 10 NOR, 11 OR.
   function automatic logic [W-1:0] ref_word(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic g, input logic o);
      case ({g, o})
         2'b00:   return ~(a & b);
         2'b01:   return a & b;
         2'b10:   return ~(a | b);
         default: return a | b;
      endcase
   endfunction

   // Issue one command from a negedge and follow it to done (bounded).
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic g, input logic o,
                         output int lat, output int bcnt, output bit sel_ok,
                         output bit lane_ok, output logic [W-1:0] res);
      op_a = a; op_b = b; select_group = g; select_op = o; start = 1'b1;
      @(posedge clk);
      lat = 0; bcnt = 0; sel_ok = 1'b1; lane_ok = 1'b1; res = 'x;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         start = 1'b0;
         if (busy) begin
            bcnt++;
            if (lu_select_op !== o || lu_select_group !== g) sel_ok = 1'b0;
            if (n - 1 < W) begin
               if (lu_a !== a[n-1] || lu_b !== b[n-1]) lane_ok = 1'b0;
            end
         end
         if (done) begin
            lat = n;
            res = result;
            if (lu_a !== 1'b0 || lu_b !== 1'b0) lane_ok = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0;
      select_op = 1'b0; select_group = 1'b0; lu_force_en = 1'b0;
      repeat (3) @(negedge clk);
      n_total++;
      if ({result, busy, done, lu_a, lu_b, lu_select_op, lu_select_group} !== '0) begin
         $display("FAIL reset_outputs got res=%h busy=%b done=%b lu_a=%b lu_b=%b sel=%b%b want all 0",
                  result, busy, done, lu_a, lu_b, lu_select_group, lu_select_op);
      end else n_pass++;
`ifdef LU_SELF_CHECK_EN
      n_total++;
      if (mismatch !== 1'b0) $display("FAIL reset_mismatch got %b want 0", mismatch);
      else n_pass++;
`endif
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_and_latency();
      int lat, bcnt; bit sel_ok, lane_ok; logic [W-1:0] res;
      run_op(8'hF0, 8'hCC, 1'b0, 1'b1, lat, bcnt, sel_ok, lane_ok, res);
      n_total++;
      if (lat !== W + 1) $display("FAIL and_latency got %0d want %0d", lat, W + 1);
      else n_pass++;
      n_total++;
      if (res !== 8'hC0) $display("FAIL and_result got %h want c0", res);
      else n_pass++;
      n_total++;
      if (bcnt !== W) $display("FAIL and_busy_cycles got %0d want %0d", bcnt, W);
      else n_pass++;
      n_total++;
      if (!lane_ok) $display("FAIL and_lanes got bad lu_a/lu_b want op bits LSB first");
      else n_pass++;
      @(negedge clk);
      n_total++;
      if (done !== 1'b0 || busy !== 1'b0 || result !== 8'hC0)
         $display("FAIL and_after_done got done=%b busy=%b res=%h want 0 0 c0", done, busy, result);
      else n_pass++;
   endtask

   task automatic test_opcodes();
      int lat, bcnt; bit sel_ok, lane_ok; logic [W-1:0] res;
      for (int k = 0; k < 4; k++) begin
         logic [1:0] opc;
         opc = 2'(k);
         run_op(8'hF0, 8'hCC, opc[1], opc[0], lat, bcnt, sel_ok, lane_ok, res);
         n_total++;
         if (res !== ref_word(8'hF0, 8'hCC, opc[1], opc[0]) || lat !== W + 1)
            $display("FAIL opcode_%0d got res=%h lat=%0d want res=%h lat=%0d",
                     k, res, lat, ref_word(8'hF0, 8'hCC, opc[1], opc[0]), W + 1);
         else n_pass++;
         n_total++;
         if (!sel_ok || lu_select_op !== opc[0] || lu_select_group !== opc[1])
            $display("FAIL opcode_%0d_selects got unstable or %b%b want %b", k,
                     lu_select_group, lu_select_op, opc);
         else n_pass++;
         @(negedge clk);
      end
   endtask

   task automatic test_start_while_busy();
      int dones = 0;
      op_a = 8'hF0; op_b = 8'hCC; select_group = 1'b0; select_op = 1'b1; start = 1'b1;
      @(posedge clk);
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         start = (n == 3);
         if (n == 3) op_a = 8'hFF;
         if (done) begin
            dones++;
            n_total++;
            if (result !== 8'hC0) $display("FAIL busy_start_result got %h want c0", result);
            else n_pass++;
         end
      end
      start = 1'b0;
      n_total++;
      if (dones !== 1) $display("FAIL busy_start_done_count got %0d want 1", dones);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      int lat, bcnt; bit sel_ok, lane_ok; logic [W-1:0] res;
      run_op(8'hF0, 8'hCC, 1'b0, 1'b1, lat, bcnt, sel_ok, lane_ok, res);
      n_total++;
      if (res !== 8'hC0) $display("FAIL b2b_first got %h want c0", res);
      else n_pass++;
      // Still in the DONE cycle: chain the next command.
      run_op(8'h0F, 8'hCC, 1'b1, 1'b1, lat, bcnt, sel_ok, lane_ok, res);
      n_total++;
      if (lat !== W + 1 || bcnt !== W)
         $display("FAIL b2b_no_idle got lat=%0d busy=%0d want %0d %0d", lat, bcnt, W + 1, W);
      else n_pass++;
      n_total++;
      if (res !== 8'hCF) $display("FAIL b2b_second got %h want cf", res);
      else n_pass++;
      @(negedge clk);
   endtask

   task automatic test_reset_mid_shift();
      int dones = 0;
      int lat, bcnt; bit sel_ok, lane_ok; logic [W-1:0] res;
      op_a = 8'hF0; op_b = 8'hCC; select_group = 1'b0; select_op = 1'b1; start = 1'b1;
      @(posedge clk);
      for (int n = 1; n <= 4; n++) begin
         @(negedge clk);
         start = 1'b0;
      end
      rst_n = 1'b0;
      #1;
      n_total++;
      if ({result, busy, done, lu_a, lu_b, lu_select_op, lu_select_group} !== '0)
         $display("FAIL midreset_outputs got res=%h busy=%b done=%b lu_a=%b lu_b=%b want all 0",
                  result, busy, done, lu_a, lu_b);
      else n_pass++;
      for (int n = 0; n < 12; n++) begin
         @(negedge clk);
         if (n == 2) rst_n = 1'b1;
         if (done) dones++;
      end
      n_total++;
      if (dones !== 0) $display("FAIL midreset_no_done got %0d want 0", dones);
      else n_pass++;
      run_op(8'h5A, 8'h3C, 1'b0, 1'b0, lat, bcnt, sel_ok, lane_ok, res);
      n_total++;
      if (res !== ref_word(8'h5A, 8'h3C, 1'b0, 1'b0) || lat !== W + 1)
         $display("FAIL midreset_restart got %h lat=%0d want %h lat=%0d",
                  res, lat, ref_word(8'h5A, 8'h3C, 1'b0, 1'b0), W + 1);
      else n_pass++;
      @(negedge clk);
   endtask

   task automatic test_random();
      int lat, bcnt; bit sel_ok, lane_ok; logic [W-1:0] res;
      for (int i = 0; i < 24; i++) begin
         logic [W-1:0] a, b; logic g, o;
         a = W'($urandom); b = W'($urandom);
         g = 1'($urandom); o = 1'($urandom);
         run_op(a, b, g, o, lat, bcnt, sel_ok, lane_ok, res);
         n_total++;
         if (res !== ref_word(a, b, g, o) || lat !== W + 1 || !sel_ok || !lane_ok)
            $display("FAIL random_%0d a=%h b=%h op=%b%b got %h lat=%0d sel=%b lane=%b want %h lat=%0d",
                     i, a, b, g, o, res, lat, sel_ok, lane_ok, ref_word(a, b, g, o), W + 1);
         else n_pass++;
         // Half the time chain from DONE, otherwise let it fall back to IDLE.
         if ($urandom_range(1, 0) == 0) @(negedge clk);
      end
      @(negedge clk);
   endtask

`ifdef LU_SELF_CHECK_EN
   task automatic test_self_check();
      int lat, bcnt; bit sel_ok, lane_ok; logic [W-1:0] res;
      lu_force_en = 1'b1;
      run_op(8'hF0, 8'hCC, 1'b0, 1'b1, lat, bcnt, sel_ok, lane_ok, res);
      lu_force_en = 1'b0;
      repeat (3) @(negedge clk);
      n_total++;
      if (mismatch !== 1'b1) $display("FAIL selfcheck_sticky got %b want 1", mismatch);
      else n_pass++;
      run_op(8'hF0, 8'hCC, 1'b0, 1'b1, lat, bcnt, sel_ok, lane_ok, res);
      n_total++;
      if (mismatch !== 1'b0 || res !== 8'hC0)
         $display("FAIL selfcheck_clear got mismatch=%b res=%h want 0 c0", mismatch, res);
      else n_pass++;
      @(negedge clk);
   endtask
`endif

   initial begin
      test_reset();
      test_and_latency();
      test_opcodes();
      test_start_while_busy();
      test_back_to_back();
      test_reset_mid_shift();
      test_random();
`ifdef LU_SELF_CHECK_EN
      test_self_check();
`endif
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
